// File: rtl/axil_master_bridge.sv
// axil_master_bridge: single-outstanding memory-request to AXI4-Lite master bridge
// with per-transaction timeout; one completion pulse per accepted request.
module axil_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic                      mem_write,
    input  logic                      mem_valid,
    output logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_ready,
    output logic [1:0]                mem_resp,
    output logic                      mem_timeout,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    timeout_q, timeout_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, busy, expired;

    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs    = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;
    assign busy    = (state_q == WR) || (state_q == WB) || (state_q == RA) || (state_q == RD);
    assign expired = (TIMEOUT_CYCLES != 0) && busy && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = busy ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            IDLE: if (mem_valid) begin
                state_d   = mem_write ? WR : RA;
                addr_d    = mem_addr & ~ADDR_WIDTH'(SW - 1);
                wdata_d   = mem_wdata;
                wstrb_d   = mem_wstrb;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                cnt_d     = '0;
            end
            WR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                state_d   = (aw_done_d && w_done_d) ? WB : WR;
            end
            WB: if (b_hs) begin
                resp_d    = M_AXI_BRESP;
                timeout_d = 1'b0;
                state_d   = DONE;
            end
            RA: state_d = ar_hs ? RD : RA;
            RD: if (r_hs) begin
                rdata_d   = M_AXI_RDATA;
                resp_d    = M_AXI_RRESP;
                timeout_d = 1'b0;
                state_d   = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A stalled slave loses the transaction; any late handshake is ignored.
        if (expired) begin
            state_d   = DONE;
            resp_d    = 2'b10;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        M_AXI_AWVALID = (state_q == WR) && !aw_done_q;
        M_AXI_WVALID  = (state_q == WR) && !w_done_q;
        M_AXI_BREADY  = state_q == WB;
        M_AXI_ARVALID = state_q == RA;
        M_AXI_RREADY  = state_q == RD;
        mem_ready     = state_q == DONE;
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign mem_rdata    = rdata_q;
    assign mem_resp     = resp_q;
    assign mem_timeout  = timeout_q;
endmodule

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: directed vectors against a delay-programmable AXI-Lite slave,
// plus back-to-back, mid-transfer reset and 64-bit sequences.
module tb_axil_master_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_write = 1'b0, mem_valid = 1'b0, mem_ready, mem_timeout;
    logic [1:0]  mem_resp;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axil_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_write(mem_write), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_timeout(mem_timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // 64-bit instance with an always-ready slave and timeout disabled
    logic [31:0] d_addr = '0, d_awaddr, d_araddr;
    logic [63:0] d_wdata = '0, d_rdata, d_wdata_o;
    logic [7:0]  d_wstrb = '0, d_wstrb_o;
    logic        d_write = 1'b0, d_valid = 1'b0, d_ready, d_tmo;
    logic        d_awvalid, d_wvalid, d_bready, d_arvalid, d_rready;
    logic [1:0]  d_resp;

    axil_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(d_addr), .mem_wdata(d_wdata), .mem_wstrb(d_wstrb),
        .mem_write(d_write), .mem_valid(d_valid),
        .mem_rdata(d_rdata), .mem_ready(d_ready), .mem_resp(d_resp), .mem_timeout(d_tmo),
        .M_AXI_AWADDR(d_awaddr), .M_AXI_AWVALID(d_awvalid), .M_AXI_AWREADY(1'b1),
        .M_AXI_WDATA(d_wdata_o), .M_AXI_WSTRB(d_wstrb_o), .M_AXI_WVALID(d_wvalid),
        .M_AXI_WREADY(1'b1),
        .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b1), .M_AXI_BREADY(d_bready),
        .M_AXI_ARADDR(d_araddr), .M_AXI_ARVALID(d_arvalid), .M_AXI_ARREADY(1'b1),
        .M_AXI_RDATA(64'hFEDCBA9876543210), .M_AXI_RRESP(2'b00), .M_AXI_RVALID(1'b1),
        .M_AXI_RREADY(d_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: each READY/VALID rises once its partner has been seen for more than *_dly cycles
    int aw_dly_c = 0, w_dly_c = 0, b_dly_c = 0, ar_dly_c = 0, r_dly_c = 0;
    logic [1:0]  resp_c = '0;
    logic [31:0] rdata_c = '0;
    int aw_k = 0, w_k = 0, b_k = 0, ar_k = 0, r_k = 0;
    int n_aw = 0, n_w = 0, n_ar = 0, n_wv = 0;
    logic [31:0] last_awaddr = '0, last_araddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    initial begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = '0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RRESP = '0; M_AXI_RDATA = '0;
        forever begin
            @(negedge clk);
            aw_k = M_AXI_AWVALID ? aw_k + 1 : 0;
            M_AXI_AWREADY = M_AXI_AWVALID && aw_k > aw_dly_c;
            if (M_AXI_AWREADY) begin n_aw++; last_awaddr = M_AXI_AWADDR; end
            w_k = M_AXI_WVALID ? w_k + 1 : 0;
            M_AXI_WREADY = M_AXI_WVALID && w_k > w_dly_c;
            if (M_AXI_WREADY) begin n_w++; last_wdata = M_AXI_WDATA; last_wstrb = M_AXI_WSTRB; end
            if (M_AXI_WVALID) n_wv++;
            b_k = M_AXI_BREADY ? b_k + 1 : 0;
            M_AXI_BVALID = M_AXI_BREADY && b_k > b_dly_c;
            M_AXI_BRESP = resp_c;
            ar_k = M_AXI_ARVALID ? ar_k + 1 : 0;
            M_AXI_ARREADY = M_AXI_ARVALID && ar_k > ar_dly_c;
            if (M_AXI_ARREADY) begin n_ar++; last_araddr = M_AXI_ARADDR; end
            r_k = M_AXI_RREADY ? r_k + 1 : 0;
            M_AXI_RVALID = M_AXI_RREADY && r_k > r_dly_c;
            M_AXI_RRESP = resp_c;
            M_AXI_RDATA = rdata_c;
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [31:0] e_addr;
        int          e_lat;
        logic [1:0]  e_resp;
        logic        e_tmo;
        int          e_ahs, e_whs, e_wv;
    } vec_t;

    vec_t vecs[10];

    task automatic run_txn(input vec_t v, input int idx);
        int a0, w0, wv0, lat;
        a0 = v.wr ? n_aw : n_ar;
        w0 = n_w;
        wv0 = n_wv;
        lat = 0;
        aw_dly_c = v.aw_dly; w_dly_c = v.w_dly; b_dly_c = v.b_dly;
        ar_dly_c = v.ar_dly; r_dly_c = v.r_dly; resp_c = v.sresp; rdata_c = v.srdata;
        @(negedge clk);
        mem_valid = 1'b1; mem_write = v.wr; mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.strb;
        @(negedge clk);
        mem_valid = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_ready) lat = c;
        end
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.e_lat));
        chk($sformatf("v%0d_resp", idx), 64'(mem_resp), 64'(v.e_resp));
        chk($sformatf("v%0d_timeout", idx), 64'(mem_timeout), 64'(v.e_tmo));
        chk($sformatf("v%0d_quiet_in_done", idx),
            64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
        if (!v.wr && !v.e_tmo) chk($sformatf("v%0d_rdata", idx), 64'(mem_rdata), 64'(v.srdata));
        @(negedge clk);
        chk($sformatf("v%0d_single_pulse", idx), 64'(mem_ready), 64'(0));
        chk($sformatf("v%0d_resp_hold", idx), 64'({mem_timeout, mem_resp}), 64'({v.e_tmo, v.e_resp}));
        chk($sformatf("v%0d_addr_hs", idx), 64'((v.wr ? n_aw : n_ar) - a0), 64'(v.e_ahs));
        if (v.e_ahs > 0)
            chk($sformatf("v%0d_axaddr", idx), 64'(v.wr ? last_awaddr : last_araddr), 64'(v.e_addr));
        if (v.wr) begin
            chk($sformatf("v%0d_w_hs", idx), 64'(n_w - w0), 64'(v.e_whs));
            chk($sformatf("v%0d_wvalid_cycles", idx), 64'(n_wv - wv0), 64'(v.e_wv));
            if (v.e_whs > 0)
                chk($sformatf("v%0d_wdata_wstrb", idx), 64'({last_wdata, last_wstrb}), 64'({v.wdata, v.strb}));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, w0, r0, pulses;
        //          wr    addr          wdata         strb    aw w  b  ar r   sresp  srdata        e_addr        lat e_resp tmo ahs whs wv
        vecs[0] = '{1'b1, 32'h0000_1003, 32'hDEADBEEF, 4'b0011, 0, 3, 2, 0, 0, 2'b00, 32'h0,        32'h0000_1000, 8, 2'b00, 1'b0, 1, 1, 4};
        vecs[1] = '{1'b0, 32'h0000_2000, 32'h0,        4'b0000, 0, 0, 0, 0, 5, 2'b10, 32'h12345678, 32'h0000_2000, 8, 2'b10, 1'b0, 1, 0, 0};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'hA5A5A5A5, 4'b1111, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0000_0010, 3, 2'b00, 1'b0, 1, 1, 1};
        vecs[3] = '{1'b0, 32'h0000_0044, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 32'h0000_0044, 3, 2'b00, 1'b0, 1, 0, 0};
        vecs[4] = '{1'b1, 32'h0000_3006, 32'h01020304, 4'b0000, 2, 0, 0, 0, 0, 2'b11, 32'h0,        32'h0000_3004, 5, 2'b11, 1'b0, 1, 1, 1};
        vecs[5] = '{1'b0, 32'h0000_2000, 32'h0,        4'b0000, 0, 0, 0, 99, 0, 2'b00, 32'h0,       32'h0,         18, 2'b10, 1'b1, 0, 0, 0};
        vecs[6] = '{1'b1, 32'h0000_4000, 32'h11112222, 4'b1010, 0, 0, 99, 0, 0, 2'b00, 32'h0,       32'h0000_4000, 18, 2'b10, 1'b1, 1, 1, 1};
        vecs[7] = '{1'b0, 32'h0000_5008, 32'h0,        4'b0000, 0, 0, 0, 1, 0, 2'b11, 32'hBAD0BAD0, 32'h0000_5008, 4, 2'b11, 1'b0, 1, 0, 0};
        vecs[8] = '{1'b1, 32'h0000_6000, 32'h33334444, 4'b0001, 0, 99, 0, 0, 0, 2'b00, 32'h0,       32'h0000_6000, 18, 2'b10, 1'b1, 1, 0, 17};
        vecs[9] = '{1'b0, 32'hFFFF_FFFE, 32'h0,        4'b0000, 0, 0, 0, 0, 2, 2'b01, 32'h00005A5A, 32'hFFFF_FFFC, 5, 2'b01, 1'b0, 1, 0, 0};

        repeat (2) @(negedge clk);
        chk("reset_ctl", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                              mem_ready, mem_timeout, mem_resp}), 64'(0));
        chk("reset_data", 64'({mem_rdata, M_AXI_AWADDR}), 64'(0));
        rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i], i);

        // write immediately followed by a read presented while DONE is showing
        a0 = n_aw; w0 = n_w; r0 = n_ar;
        aw_dly_c = 0; w_dly_c = 0; b_dly_c = 0; ar_dly_c = 0; r_dly_c = 0;
        resp_c = 2'b00; rdata_c = 32'h7777_0001;
        @(negedge clk);
        mem_valid = 1'b1; mem_write = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h55; mem_wstrb = 4'hF;
        @(negedge clk);
        mem_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                if (pulses == 1) begin mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 32'h600; end
            end
            if (M_AXI_ARVALID) mem_valid = 1'b0;
        end
        mem_valid = 1'b0;
        chk("b2b_aw_count", 64'(n_aw - a0), 64'(1));
        chk("b2b_w_count", 64'(n_w - w0), 64'(1));
        chk("b2b_ar_count", 64'(n_ar - r0), 64'(1));
        chk("b2b_araddr", 64'(last_araddr), 64'(32'h600));
        chk("b2b_pulses", 64'(pulses), 64'(2));
        chk("b2b_rdata", 64'(mem_rdata), 64'(32'h7777_0001));

        // reset while AW and W are both pending
        aw_dly_c = 99; w_dly_c = 99;
        @(negedge clk);
        mem_valid = 1'b1; mem_write = 1'b1; mem_addr = 32'h700; mem_wdata = 32'h11; mem_wstrb = 4'hF;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                                  mem_ready, mem_timeout, mem_resp}), 64'(0));
        chk("rst_async_addr_rdata", 64'({mem_rdata, M_AXI_AWADDR}), 64'(0));
        chk("rst_async_wdata", 64'({M_AXI_WDATA, M_AXI_WSTRB}), 64'(0));
        pulses = 0;
        repeat (3) begin @(negedge clk); if (mem_ready) pulses++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (mem_ready) pulses++; end
        chk("rst_no_ready", 64'(pulses), 64'(0));
        run_txn(vecs[2], 100);

        // 64-bit write then read
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h0F; d_wstrb = 8'hF0; d_wdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        d_valid = 1'b0;
        chk("w64_awaddr", 64'(d_awaddr), 64'(32'h08));
        chk("w64_wstrb", 64'(d_wstrb_o), 64'(8'hF0));
        chk("w64_wdata", d_wdata_o, 64'h0123456789ABCDEF);
        chk("w64_valids", 64'({d_awvalid, d_wvalid}), 64'(2'b11));
        repeat (2) @(negedge clk);
        chk("w64_done", 64'({d_ready, d_tmo, d_resp}), 64'(4'b1000));
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h2C;
        @(negedge clk);
        d_valid = 1'b0;
        chk("r64_araddr", 64'({d_arvalid, d_araddr}), 64'({1'b1, 32'h28}));
        repeat (2) @(negedge clk);
        chk("r64_done", 64'({d_ready, d_tmo, d_resp}), 64'(4'b1000));
        chk("r64_rdata", d_rdata, 64'hFEDCBA9876543210);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_master_bridge.md
AXIL_MASTER_BRIDGE -- requirements
Module: axil_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of bus and AXI ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 or 64 legal.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, per-transaction cycle limit; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports mem_addr  input  ADDR_WIDTH  request address; mem_wdata  input  DATA_WIDTH  write data.
REQ-007 SHALL have port mem_wstrb  input  DATA_WIDTH/8  byte enables.
REQ-008 SHALL have ports mem_write  input  1  1=write, 0=read; mem_valid  input  1  request present.
REQ-009 SHALL have ports mem_rdata  output  DATA_WIDTH  read data; mem_ready  output  1  completion pulse.
REQ-010 SHALL have ports mem_resp  output  2  AXI response code; mem_timeout  output  1  completion was a timeout.
REQ-011 SHALL have AW ports M_AXI_AWADDR out ADDR_WIDTH, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-012 SHALL have W ports M_AXI_WDATA out DATA_WIDTH, M_AXI_WSTRB out DATA_WIDTH/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-013 SHALL have B ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-014 SHALL have AR ports M_AXI_ARADDR out ADDR_WIDTH, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-015 SHALL have R ports M_AXI_RDATA in DATA_WIDTH, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-016 SHALL implement states IDLE, WR (AW/W pending), WB (await B), RA (AR pending), RD (await R), DONE.
REQ-017 SHALL accept a request only in IDLE with mem_valid=1, registering addr/wdata/wstrb at that edge; next state WR if mem_write else RA.
REQ-018 SHALL force the low log2(DATA_WIDTH/8) address bits to zero on AWADDR/ARADDR; WSTRB = mem_wstrb unmodified (all-zero passed through).
REQ-019 SHALL assert AWVALID and WVALID together in the first WR cycle; each drops independently the cycle after its own VALID&READY edge.
REQ-020 SHALL go WR->WB once both AW and W handshakes completed, including both in the same edge; never re-issue a completed channel.
REQ-021 SHALL hold BREADY=1 only in WB, RREADY=1 only in RD, ARVALID=1 only in RA; RA->RD on ARREADY edge.
REQ-022 SHALL capture BRESP on B handshake, RRESP and RDATA on R handshake (RDATA captured even for SLVERR/DECERR), then enter DONE.
REQ-023 SHALL in DONE drive mem_ready=1 for exactly one cycle with mem_resp/mem_timeout valid, then return to IDLE; mem_valid ignored in DONE.
REQ-024 SHALL hold mem_rdata, mem_resp, mem_timeout stable from DONE until the next DONE.
REQ-025 SHALL never deassert a VALID before its handshake except on timeout or reset.
REQ-026 SHALL clear a timeout counter on acceptance and increment it every cycle in WR/WB/RA/RD.
REQ-027 SHALL, when TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES, drop all VALID/READY next edge, enter DONE with mem_resp=2'b10, mem_timeout=1.
REQ-028 SHALL give minimum latency 3 cycles accept-to-mem_ready with all AXI readies/valids immediate (write) and 3 (read).

Reset
REQ-029 SHALL on rst_n=0 asynchronously force state IDLE and all VALID/READY, mem_ready, mem_resp, mem_timeout, mem_rdata, captured address/data registers to 0.
REQ-030 SHALL abandon any in-flight transaction on reset with no completion pulse.

Verification
REQ-031 Write addr 0x1003, data 0xDEADBEEF, strb 0011, AWREADY=1, WREADY after 3 cycles, BVALID 2 cycles later OKAY -> AWADDR 0x1000, WVALID high 4 cycles, one mem_ready pulse, mem_resp 00.
REQ-032 Read 0x2000, ARREADY=1, RVALID 5 cycles later, RDATA 0x12345678, RRESP 10 -> mem_rdata 0x12345678, mem_resp 10, mem_timeout 0, single mem_ready.
REQ-033 TIMEOUT_CYCLES=16, read with ARREADY held 0 -> ARVALID drops, mem_ready with mem_timeout=1, mem_resp 10, 18 cycles after accept.
REQ-034 Write completing then read presented cycle after mem_ready -> exactly one AW/W pair and one AR issued, no duplicate write.
REQ-035 rst_n low while AWVALID=WVALID=1 -> all outputs 0 immediately, no mem_ready; next write after release completes normally.
REQ-036 DATA_WIDTH=64, write addr 0x0F, strb 0xF0 -> AWADDR 0x08, WSTRB 0xF0, WDATA 64-bit passed intact.
